// File: rtl/btb_ctrl.sv
// BTB write-port controller: post-reset/flush init sweep, buffered MEM-stage
// target updates, and saturating branch/hit statistics.
module btb_ctrl #(
  parameter int NUM_ENTRIES = 256,
  parameter int IDX_W       = 8,
  parameter int ENTRY_WIDTH = 40,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   flush_req,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [31:0]            upd_pc,
  input  logic [31:0]            upd_target,
  input  logic                   is_branch,
  input  logic                   hit,
  output logic                   btb_we,
  output logic [IDX_W-1:0]       btb_addr,
  output logic [ENTRY_WIDTH-1:0] btb_wdata,
  output logic                   busy,
  output logic [15:0]            br_cnt,
  output logic [15:0]            hit_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [ENTRY_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [15:0]            r_br_cnt, r_hit_cnt;

  logic                   w_empty, w_full, w_push, w_pop;
  logic [ENTRY_WIDTH-1:0] w_head;
  logic                   w_unused;

  // Only the word-index bits of the PC reach the BTB.
  assign w_unused = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push  = upd_valid && !w_full && !flush_req;
  assign w_pop   = (r_state == S_RUN) && !w_empty;
  assign w_head  = r_fifo[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_INIT: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == IDX_W'(NUM_ENTRIES - 1)) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
        end
      end
      default: ;
    endcase
    if (flush_req) begin
      w_state_nxt = S_INIT;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Flush drops queued entries; a pop issued in the flush cycle still writes.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_req) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {upd_pc[IDX_W+1:2], upd_target};
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_br_cnt  <= '0;
      r_hit_cnt <= '0;
    end else begin
      if (is_branch && (r_br_cnt != 16'hFFFF))          r_br_cnt  <= r_br_cnt + 1'b1;
      if (is_branch && hit && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  always_comb begin
    btb_addr  = '0;
    btb_wdata = '0;
    if (r_state == S_INIT) begin
      btb_addr  = r_idx;
      btb_wdata = {r_idx, 32'h0};
    end else if (w_pop) begin
      btb_addr  = w_head[ENTRY_WIDTH-1 -: IDX_W];
      btb_wdata = w_head;
    end
  end

  assign btb_we    = rst_i && ((r_state == S_INIT) || w_pop);
  assign busy      = (r_state == S_INIT);
  assign upd_ready = !w_full;
  assign br_cnt    = r_br_cnt;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: table-driven RUN vectors plus hand-written
// sweep, backpressure, flush, saturation and async-reset sequences.
module tb_btb_ctrl;

  logic        clk, rst_i, flush_req, upd_valid, upd_ready;
  logic [31:0] upd_pc, upd_target;
  logic        is_branch, hit, btb_we, busy;
  logic [7:0]  btb_addr;
  logic [39:0] btb_wdata;
  logic [15:0] br_cnt, hit_cnt;

  int checks = 0;
  int errors = 0;
  logic [39:0] wq[$];
  logic        acc_busy;
  int          last_wait;

  btb_ctrl #(.NUM_ENTRIES(256), .IDX_W(8), .ENTRY_WIDTH(40), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_i(rst_i), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .is_branch(is_branch), .hit(hit),
    .btb_we(btb_we), .btb_addr(btb_addr), .btb_wdata(btb_wdata),
    .busy(busy), .br_cnt(br_cnt), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every update write (sweep writes excluded), once per cycle.
  always @(negedge clk) begin
    if (rst_i && btb_we && !busy) wq.push_back(btb_wdata);
  end

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] tg;
    logic        br;
    logic        ht;
    logic        we;
    logic [7:0]  addr;
    logic [39:0] wd;
    logic [15:0] ebr;
    logic [15:0] ehit;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] pc, input logic [31:0] tg);
    int n;
    n = 0;
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tg;
    while (!upd_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 64'(n < 600), 64'd1);
    acc_busy  = busy;
    last_wait = n;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    chk("flush_busy", 64'(busy), 64'd1);
    chk("flush_addr", 64'(btb_addr), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_timeout", 64'(n < 400), 64'd1);
  endtask

  function automatic logic [39:0] ent(input logic [31:0] pc, input logic [31:0] tg);
    return {pc[9:2], tg};
  endfunction

  initial begin
    logic [31:0] pcs[6];
    logic [31:0] tgs[6];
    int n;

    vecs[0] = '{1'b1, 32'h0000_0124, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 8'h49, 40'h49_0000_0200, 16'd1, 16'd1};
    vecs[1] = '{1'b1, 32'h0000_03FC, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 8'hFF, 40'hFF_DEAD_BEEF, 16'd2, 16'd1};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h00, 40'h0,            16'd2, 16'd1};
    vecs[3] = '{1'b1, 32'h1000_0008, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 8'h02, 40'h02_0000_0004, 16'd2, 16'd1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 8'hFF, 40'hFF_8000_0000, 16'd3, 16'd2};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'h00, 40'h0,            16'd3, 16'd2};

    rst_i = 1'b0; flush_req = 1'b0; upd_valid = 1'b0;
    upd_pc = '0; upd_target = '0; is_branch = 1'b0; hit = 1'b0;

    // Reset state
    #1;
    chk("rst_we", 64'(btb_we), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_addr", 64'(btb_addr), 64'd0);
    chk("rst_wdata", 64'(btb_wdata), 64'd0);
    chk("rst_br", 64'(br_cnt), 64'd0);
    chk("rst_hit", 64'(hit_cnt), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_we_held", 64'(btb_we), 64'd0);

    // Sweep after release
    rst_i = 1'b1;
    for (int k = 0; k < 256; k++) begin
      #1;
      chk("sweep_we", 64'(btb_we), 64'd1);
      chk("sweep_addr", 64'(btb_addr), 64'(k));
      chk("sweep_wdata", 64'(btb_wdata), {24'h0, 8'(k), 32'h0});
      chk("sweep_busy", 64'(busy), 64'd1);
      chk("sweep_ready", 64'(upd_ready), 64'd1);
      @(negedge clk);
    end
    #1;
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_we", 64'(btb_we), 64'd0);

    // Table vectors in RUN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      upd_valid = vecs[i].v; upd_pc = vecs[i].pc; upd_target = vecs[i].tg;
      is_branch = vecs[i].br; hit = vecs[i].ht;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), 64'(btb_we), 64'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), 64'(btb_addr), 64'(vecs[i].addr));
        chk($sformatf("v%0d_wdata", i), 64'(btb_wdata), 64'(vecs[i].wd));
      end
      chk($sformatf("v%0d_ready", i), 64'(upd_ready), 64'd1);
      chk($sformatf("v%0d_br", i), 64'(br_cnt), 64'(vecs[i].ebr));
      chk($sformatf("v%0d_hit", i), 64'(hit_cnt), 64'(vecs[i].ehit));
    end
    upd_valid = 1'b0; is_branch = 1'b0; hit = 1'b0;

    // Statistics saturation (start br=3, hit=2)
    @(negedge clk);
    is_branch = 1'b1; hit = 1'b1;
    repeat (65532) @(posedge clk);
    #1;
    chk("sat_br_edge", 64'(br_cnt), 64'hFFFF);
    chk("sat_hit_edge", 64'(hit_cnt), 64'hFFFE);
    repeat (8) @(posedge clk);
    #1;
    chk("sat_br", 64'(br_cnt), 64'hFFFF);
    chk("sat_hit", 64'(hit_cnt), 64'hFFFF);
    is_branch = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_hit_nobr", 64'(hit_cnt), 64'hFFFF);
    hit = 1'b0;

    // Backpressure and order: 6 requests during INIT
    for (int i = 0; i < 6; i++) begin
      pcs[i] = 32'h0000_0100 + 32'(4 * i);
      tgs[i] = 32'hA000_0000 + 32'(i);
    end
    do_flush();
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      push_req(pcs[i], tgs[i]);
      if (i == 3) begin
        chk("bp_ready_low", 64'(upd_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
      end
      if (i >= 4) begin
        chk($sformatf("bp_acc%0d_busy", i), 64'(acc_busy), 64'd0);
        chk($sformatf("bp_acc%0d_waited", i), 64'(last_wait > 0), 64'(i == 4));
      end
    end
    n = 0;
    while (wq.size() < 6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("bp_nwrites", 64'(wq.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (wq.size() > i) chk($sformatf("bp_order%0d", i), 64'(wq[i]), 64'(ent(pcs[i], tgs[i])));
    end

    // Flush with entries queued plus a same-cycle push
    do_flush();
    wq.delete();
    for (int i = 0; i < 4; i++) push_req(pcs[i] + 32'h40, tgs[i] + 32'h10);
    wait_idle();
    chk("fl_first", 64'(btb_wdata), 64'(ent(pcs[0] + 32'h40, tgs[0] + 32'h10)));
    @(negedge clk);
    chk("fl_second", 64'(btb_wdata), 64'(ent(pcs[1] + 32'h40, tgs[1] + 32'h10)));
    chk("fl_second_we", 64'(btb_we), 64'd1);
    flush_req = 1'b1; upd_valid = 1'b1;
    upd_pc = 32'h0000_0380; upd_target = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    flush_req = 1'b0; upd_valid = 1'b0;
    chk("fl_busy", 64'(busy), 64'd1);
    chk("fl_addr", 64'(btb_addr), 64'd0);
    chk("fl_wdata", 64'(btb_wdata), 64'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("fl_nwrites", 64'(wq.size()), 64'd2);
    chk("fl_idle_we", 64'(btb_we), 64'd0);
    chk("fl_ready", 64'(upd_ready), 64'd1);

    // Async reset mid-sweep
    do_flush();
    n = 0;
    while (btb_addr != 8'd100 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ar_reach100", 64'(btb_addr), 64'd100);
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar_we", 64'(btb_we), 64'd0);
    chk("ar_addr", 64'(btb_addr), 64'd0);
    chk("ar_busy", 64'(busy), 64'd1);
    chk("ar_ready", 64'(upd_ready), 64'd1);
    chk("ar_br", 64'(br_cnt), 64'd0);
    chk("ar_hit", 64'(hit_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("ar_restart_we", 64'(btb_we), 64'd1);
    chk("ar_restart_addr0", 64'(btb_addr), 64'd0);
    @(negedge clk);
    #1;
    chk("ar_restart_addr1", 64'(btb_addr), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
